// File: rtl/compressor_sequencer.sv
// Sequencer feeding row beats into a bit-serial compressor's operand shift registers,
// then waiting a fixed settle time and handing the captured result to a consumer.
module compressor_sequencer #(
    parameter int ROWS    = 12,
    parameter int COLS    = 12,
    parameter int DW      = 17,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [COLS-1:0] in_data,
    input  logic            abort,
    output logic            sh_en,
    output logic [COLS-1:0] sh_bits,
    output logic            sh_clr,
    input  logic [DW-1:0]   res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            busy
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

    state_t          state_reg;
    logic [RW-1:0]   row_cnt_reg;
    logic [3:0]      wait_cnt_reg;
    logic            out_valid_reg;
    logic [DW-1:0]   out_data_reg;

    logic in_load;
    logic handoff;

    // Reset gates every combinational output so the shift registers stay cleared while rst is high.
    assign in_load  = (state_reg == LOAD) && !rst;
    assign handoff  = (state_reg == OUT) && out_valid_reg && out_ready && !rst;

    assign in_ready = in_load;
    assign sh_en    = in_load && in_valid && !abort;
    assign sh_clr   = rst || (in_load && abort) || handoff;
    assign busy     = !rst && !((state_reg == LOAD) && (row_cnt_reg == '0));

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_bits
            assign sh_bits[gi] = in_data[gi] && in_load;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            row_cnt_reg   <= '0;
            wait_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (abort) begin
                        row_cnt_reg <= '0;
                    end else if (in_valid) begin
                        if (row_cnt_reg == RW'(ROWS - 1)) begin
                            row_cnt_reg  <= '0;
                            wait_cnt_reg <= 4'(LATENCY);
                            state_reg    <= WAIT;
                        end else begin
                            row_cnt_reg <= row_cnt_reg + RW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end else begin
                        out_data_reg  <= res;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= LOAD;
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_compressor_sequencer.sv
// Bench for compressor_sequencer: two instances (LATENCY 2 and 0) share stimulus and are
// compared every cycle against a timing-based job model, plus directed literal checks.
module tb_compressor_sequencer;
    localparam int ROWS = 12;
    localparam int COLS = 12;
    localparam int DW   = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            abort = 1'b0;
    logic            out_ready = 1'b0;
    logic [COLS-1:0] in_data = '0;
    logic [DW-1:0]   res = '0;

    logic            a_in_ready, a_sh_en, a_sh_clr, a_out_valid, a_busy;
    logic [COLS-1:0] a_sh_bits;
    logic [DW-1:0]   a_out_data;
    logic            b_in_ready, b_sh_en, b_sh_clr, b_out_valid, b_busy;
    logic [COLS-1:0] b_sh_bits;
    logic [DW-1:0]   b_out_data;

    compressor_sequencer #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .abort(abort), .sh_en(a_sh_en), .sh_bits(a_sh_bits), .sh_clr(a_sh_clr), .res(res),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy)
    );

    compressor_sequencer #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .abort(abort), .sh_en(b_sh_en), .sh_bits(b_sh_bits), .sh_clr(b_sh_clr), .res(res),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .busy(b_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Job model: rows collected so far, the cycle in which the result is captured, and the held result.
    int            m_rows[2] = '{0, 0};
    int            m_done[2] = '{-1, -1};
    bit            m_hold[2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_data[2] = '{'0, '0};

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    endtask

    task automatic model_step(input int k, input int lat, input logic ir, input logic se,
                              input logic sc, input logic ov, input logic bz,
                              input logic [COLS-1:0] sb, input logic [DW-1:0] od);
        bit loading;
        bit e_ir;
        loading = !m_hold[k] && (m_done[k] < 0);
        e_ir    = !rst && loading;
        chk("in_ready", k, 32'(ir), 32'(e_ir));
        chk("sh_en", k, 32'(se), 32'(e_ir && in_valid && !abort));
        chk("sh_bits", k, 32'(sb), e_ir ? 32'(in_data) : 32'd0);
        chk("sh_clr", k, 32'(sc), 32'(rst || (e_ir && abort) || (!rst && m_hold[k] && out_ready)));
        chk("busy", k, 32'(bz), 32'(!rst && !(loading && m_rows[k] == 0)));
        chk("out_valid", k, 32'(ov), 32'(m_hold[k]));
        chk("out_data", k, 32'(od), 32'(m_data[k]));
        if (rst) begin
            m_rows[k] = 0; m_done[k] = -1; m_hold[k] = 1'b0; m_data[k] = '0;
        end else if (loading) begin
            if (abort) m_rows[k] = 0;
            else if (in_valid) begin
                m_rows[k]++;
                if (m_rows[k] == ROWS) begin
                    m_rows[k] = 0;
                    m_done[k] = cyc + lat + 1;
                end
            end
        end else if (!m_hold[k]) begin
            if (cyc == m_done[k]) begin
                m_data[k] = res; m_hold[k] = 1'b1; m_done[k] = -1;
            end
        end else if (out_ready) begin
            m_hold[k] = 1'b0;
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_step(0, 2, a_in_ready, a_sh_en, a_sh_clr, a_out_valid, a_busy, a_sh_bits, a_out_data);
            model_step(1, 0, b_in_ready, b_sh_en, b_sh_clr, b_out_valid, b_busy, b_sh_bits, b_out_data);
            cyc++;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic run_beats(input int n, input bit fixed, input logic [COLS-1:0] d, output int nsh);
        nsh = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = fixed ? d : COLS'($urandom);
            @(negedge clk);
            if (a_sh_en && a_sh_bits == in_data) nsh++;
            next_cycle();
        end
    endtask

    task automatic wait_result(output int ra, output int rb, output logic [DW-1:0] oda, output logic sca);
        ra = -1; rb = -1; oda = '0; sca = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (a_out_valid && ra < 0) begin ra = t; oda = a_out_data; sca = a_sh_clr; end
            if (b_out_valid && rb < 0) rb = t;
            next_cycle();
        end
    endtask

    initial begin
        int nsh, ra, rb, cnt, got;
        logic [DW-1:0] oda, val;
        logic sca;

        @(negedge clk);
        chk("rst_sh_clr", 0, 32'(a_sh_clr), 32'd1);
        chk("rst_in_ready", 0, 32'(a_in_ready), 32'd0);
        chk("rst_busy", 0, 32'(a_busy), 32'd0);
        chk("rst_out_data", 0, 32'(a_out_data), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 0, 32'(a_in_ready), 32'd1);
        chk("post_rst_sh_clr", 0, 32'(a_sh_clr), 32'd0);
        next_cycle();

        // Nominal job
        res = 17'h0BFF4; out_ready = 1'b1;
        run_beats(12, 1'b1, 12'hFFF, nsh);
        in_valid = 1'b0;
        wait_result(ra, rb, oda, sca);
        chk("nom_shifts", 0, 32'(nsh), 32'd12);
        chk("nom_rise", 0, 32'(ra), 32'd4);
        chk("nom_rise_lat0", 1, 32'(rb), 32'd2);
        chk("nom_data", 0, 32'(oda), 32'h0BFF4);
        chk("nom_sh_clr", 0, 32'(sca), 32'd1);

        // Backpressure with in_valid held
        out_ready = 1'b0; val = DW'($urandom); res = val;
        run_beats(12, 1'b0, '0, nsh);
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            @(negedge clk);
            got = int'(a_out_valid);
            next_cycle();
        end
        chk("bp_valid", 0, 32'(got), 32'd1);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            res = DW'($urandom);
            @(negedge clk);
            cnt += int'(a_sh_en) + int'(a_in_ready) + int'(b_sh_en);
            chk("bp_hold_data", 0, 32'(a_out_data), 32'(val));
            next_cycle();
        end
        chk("bp_no_shift", 0, 32'(cnt), 32'd0);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_clr", 0, 32'(a_sh_clr), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("bp_back_load", 0, 32'(a_in_ready && !a_out_valid), 32'd1);
        next_cycle();

        // Bubbles: in_valid toggling
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = COLS'($urandom);
            @(negedge clk);
            cnt += int'(a_sh_en);
            next_cycle();
        end
        in_valid = 1'b0;
        wait_result(ra, rb, oda, sca);
        chk("bub_shifts", 0, 32'(cnt), 32'd12);
        chk("bub_rise", 0, 32'(ra), 32'd3);

        // Abort at row 5 overriding in_valid
        run_beats(5, 1'b0, '0, nsh);
        in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("abort_no_shift", 0, 32'(a_sh_en), 32'd0);
        chk("abort_sh_clr", 0, 32'(a_sh_clr), 32'd1);
        next_cycle();
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", 0, 32'(a_busy || b_busy), 32'd0);
        next_cycle();
        run_beats(12, 1'b0, '0, nsh);
        in_valid = 1'b0;
        wait_result(ra, rb, oda, sca);
        chk("abort_job_shifts", 0, 32'(nsh), 32'd12);
        chk("abort_job_rise", 0, 32'(ra), 32'd4);
        chk("abort_job_rise_lat0", 1, 32'(rb), 32'd2);

        // Abort during WAIT/OUT is ignored
        out_ready = 1'b0;
        run_beats(12, 1'b0, '0, nsh);
        in_valid = 1'b0; abort = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            if (t == 2) chk("lat0_abort_out", 1, 32'(b_out_valid), 32'd1);
            if (t == 4) chk("abort_out", 0, 32'(a_out_valid), 32'd1);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_out_clr", 0, 32'(a_sh_clr && b_sh_clr), 32'd1);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_out_done", 0, 32'(a_out_valid || b_out_valid), 32'd0);
        next_cycle();

        // Reset mid-WAIT
        run_beats(12, 1'b0, '0, nsh);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_sh_clr", 0, 32'(a_sh_clr), 32'd1);
        chk("midrst_busy", 0, 32'(a_busy), 32'd0);
        next_cycle();
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            cnt += int'(a_out_valid) + int'(b_out_valid);
            next_cycle();
        end
        chk("midrst_no_valid", 0, 32'(cnt), 32'd0);
        res = 17'h0BFF4;
        run_beats(12, 1'b1, 12'hFFF, nsh);
        in_valid = 1'b0;
        wait_result(ra, rb, oda, sca);
        chk("midrst_rise", 0, 32'(ra), 32'd4);
        chk("midrst_data", 0, 32'(oda), 32'h0BFF4);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 200) == 0;
            in_valid  = ($urandom % 10) < 7;
            abort     = ($urandom % 25) == 0;
            out_ready = $urandom % 2;
            in_data   = COLS'($urandom);
            res       = DW'($urandom);
            next_cycle();
        end
        rst = 1'b0; in_valid = 1'b0; abort = 1'b0;
        repeat (2) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
